// File: rtl/n64_vdemux.sv
// n64_vdemux: demultiplexes the N64 4-phase video bus (sync, R, G, B) into a
// packed pixel word and derives interlace / PAL detection from the line count
// measured between vertical sync falling edges.
module n64_vdemux #(
   parameter int color_width = 7
) (
   input  logic                         VCLK,
   input  logic                         nVRST,
   input  logic                         nVDSYNC,
   input  logic [color_width-1:0]       VD_i,
   output logic [3+3*color_width:0]     vdata_o,
   output logic                         vdata_valid_o,
   output logic                         demux_err_o,
   output logic                         n64_480i_o,
   output logic                         palmode_o
);

   localparam int PW = 4 + 3 * color_width;

   // Pixel word layout: {nVSYNC, nCLAMP, nHSYNC, nCSYNC, R, G, B}
   localparam int VS_BIT = PW - 1;
   localparam int HS_BIT = PW - 3;

   // Sync bits idle high, colours black
   localparam logic [PW-1:0] RST_PX = {4'hF, {(3*color_width){1'b0}}};

   // Phase encoding: PH_S doubles as the idle wait state after a pixel
   localparam logic [1:0] PH_S = 2'd0;
   localparam logic [1:0] PH_R = 2'd1;
   localparam logic [1:0] PH_G = 2'd2;
   localparam logic [1:0] PH_B = 2'd3;

   localparam logic [9:0] LINES_MAX = 10'd1023;
   localparam logic [9:0] PAL_MIN   = 10'd288;

   logic [1:0]             r_phase;
   logic [3:0]             r_sync;
   logic [color_width-1:0] r_red;
   logic [color_width-1:0] r_grn;
   logic [color_width-1:0] r_blu;
   logic                   r_commit;
   logic [PW-1:0]          r_vdata;
   logic                   r_valid;
   logic                   r_err;
   logic [9:0]             r_lines;
   logic [9:0]             r_last;
   logic                   r_first;
   logic                   r_480i;
   logic                   r_pal;

   logic [PW-1:0]          w_new_px;
   logic                   w_vs_fall;
   logic                   w_hs_fall;
   logic                   w_sat;
   logic [9:0]             w_lines_inc;
   logic                   w_diff_one;
   logic                   w_is_pal;

   // The pixel about to be committed, assembled from the shadow registers
   assign w_new_px    = {r_sync, r_red, r_grn, r_blu};

   // Edges are judged between the previously committed pixel and the new one
   assign w_vs_fall   = r_commit & r_vdata[VS_BIT] & ~w_new_px[VS_BIT];
   assign w_hs_fall   = r_commit & r_vdata[HS_BIT] & ~w_new_px[HS_BIT];

   assign w_sat       = (r_lines == LINES_MAX);
   assign w_lines_inc = w_sat ? LINES_MAX : (r_lines + 10'd1);

   // 11-bit compare so last_cnt=1023 / count=0 does not alias to a difference of 1
   assign w_diff_one  = ({1'b0, r_lines} == ({1'b0, r_last} + 11'd1)) ||
                        ({1'b0, r_last}  == ({1'b0, r_lines} + 11'd1));
   assign w_is_pal    = (r_lines > PAL_MIN);

   // Bus phase tracking and capture of sync/colour samples into shadow registers
   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         r_phase  <= PH_S;
         r_sync   <= 4'hF;
         r_red    <= {color_width{1'b0}};
         r_grn    <= {color_width{1'b0}};
         r_blu    <= {color_width{1'b0}};
         r_commit <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_commit <= 1'b0;
         r_err    <= 1'b0;
         if (!nVDSYNC) begin
            // A sync sample always restarts the pixel; a partial one is flagged
            r_sync  <= VD_i[3:0];
            r_phase <= PH_R;
            r_err   <= (r_phase != PH_S);
         end else begin
            case (r_phase)
               PH_R: begin
                  r_red   <= VD_i;
                  r_phase <= PH_G;
               end
               PH_G: begin
                  r_grn   <= VD_i;
                  r_phase <= PH_B;
               end
               PH_B: begin
                  r_blu    <= VD_i;
                  r_phase  <= PH_S;
                  r_commit <= 1'b1;
               end
               default: begin
                  r_phase <= PH_S;
               end
            endcase
         end
      end
   end

   // Output pixel register: loaded one cycle after the B sample, held otherwise
   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         r_vdata <= RST_PX;
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_commit;
         if (r_commit) begin
            r_vdata <= w_new_px;
         end else begin
            r_vdata <= r_vdata;
         end
      end
   end

   // Line counting between vsync falls and interlace / PAL classification
   always_ff @(posedge VCLK or negedge nVRST) begin
      if (!nVRST) begin
         r_lines <= 10'd0;
         r_last  <= 10'd0;
         r_first <= 1'b0;
         r_480i  <= 1'b0;
         r_pal   <= 1'b0;
      end else if (w_vs_fall) begin
         // Count is stored before any coinciding hsync increment
         r_last  <= r_lines;
         r_lines <= w_hs_fall ? 10'd1 : 10'd0;
         r_first <= 1'b1;
         if (r_first) begin
            if (w_sat) begin
               r_480i <= 1'b0;
               r_pal  <= r_pal;
            end else begin
               r_480i <= w_diff_one;
               r_pal  <= w_is_pal;
            end
         end else begin
            r_480i <= r_480i;
            r_pal  <= r_pal;
         end
      end else if (w_hs_fall) begin
         r_lines <= w_lines_inc;
      end else begin
         r_lines <= r_lines;
      end
   end

   assign vdata_o       = r_vdata;
   assign vdata_valid_o = r_valid;
   assign demux_err_o   = r_err;
   assign n64_480i_o    = r_480i;
   assign palmode_o     = r_pal;

endmodule
